// File: rtl/j0_tag_fifo_pkg.sv
// Shared widths, word-field positions and helpers for the J0 tag receiver.
package j0_tag_fifo_pkg;

    localparam int J0_ETAG_W    = 3;
    localparam int J0_STAG_W    = 2;
    localparam int EVNUM_W      = 15;
    localparam int LOST_W       = 16;
    localparam int WORD_W       = 32;

    localparam int MISMATCH_BIT = 31;
    localparam int EVNUM_LSB    = 16;
    localparam int STAG_LSB     = 3;
    localparam int ETAG_LSB     = 0;

    function automatic logic [J0_ETAG_W-1:0] etag_next(
        input logic [J0_ETAG_W-1:0] e
    );
        return e + 1'b1;
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(
        input logic                 mm,
        input logic [EVNUM_W-1:0]   ev,
        input logic [J0_STAG_W-1:0] stag,
        input logic [J0_ETAG_W-1:0] etag
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[MISMATCH_BIT]                 = mm;
        w[EVNUM_LSB +: EVNUM_W]         = ev;
        w[STAG_LSB +: J0_STAG_W]        = stag;
        w[ETAG_LSB +: J0_ETAG_W]        = etag;
        return w;
    endfunction

endpackage

// File: rtl/tag_fifo_mem.sv
// DEPTH x 32 register file: synchronous write, registered show-ahead read
// with write-through when the written slot is the next head.
module tag_fifo_mem
    import j0_tag_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_q
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            if (i_we && (i_waddr == i_raddr)) begin
                r_q <= i_wdata;
            end else begin
                r_q <= r_mem[i_raddr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/j0_tag_fifo.sv
// J0 trigger/tag slave: synchronises triggers, stamps tags with an event
// number and consistency flag, buffers them and drives BUSY_J0 back.
module j0_tag_fifo
    import j0_tag_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int AFULL = 12
) (
    input  logic                 SYSCLK,
    input  logic                 RSTB,
    input  logic                 TRIG_J0,
    input  logic [J0_STAG_W-1:0] STAG_J0,
    input  logic [J0_ETAG_W-1:0] ETAG_J0,
    input  logic                 BUSY_LOCAL,
    input  logic                 CLR,
    input  logic                 RD_POP,
    output logic [WORD_W-1:0]    DOUT,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic [AW:0]          COUNT,
    output logic [LOST_W-1:0]    LOST,
    output logic                 BUSY_J0
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_AFULL = (AW+1)'(AFULL);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_edge;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW:0]          r_cnt;
    logic                 r_empty;
    logic                 r_full;
    logic [LOST_W-1:0]    r_lost;
    logic [EVNUM_W-1:0]   r_evnum;
    logic [J0_ETAG_W-1:0] r_prev_etag;
    logic                 r_first;
    logic                 r_busy_n;
    logic                 r_run;

    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_acc;
    logic                 w_drop;
    logic                 w_mm;
    logic [WORD_W-1:0]    w_word;
    logic [AW:0]          w_cnt_nxt;
    logic [AW-1:0]        w_rd_nxt;
    logic [AW-1:0]        w_wr_nxt;
    logic                 w_re;

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= TRIG_J0;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign w_push_req = r_sync2 & ~r_edge;

    // A full FIFO is never empty, so a coincident pop always frees a slot.
    assign w_pop  = RD_POP & ~r_empty & ~CLR;
    assign w_acc  = w_push_req & ~CLR & (~r_full | RD_POP);
    assign w_drop = w_push_req & ~CLR & ~w_acc;

    assign w_mm   = ~r_first & (ETAG_J0 != etag_next(r_prev_etag));
    assign w_word = pack_word(w_mm, r_evnum, STAG_J0, ETAG_J0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_rd_nxt  = r_rd_ptr;
        w_wr_nxt  = r_wr_ptr;
        if (CLR) begin
            w_cnt_nxt = '0;
            w_rd_nxt  = '0;
            w_wr_nxt  = '0;
        end else begin
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + 1'b1;
            end
            if (w_acc) begin
                w_wr_nxt = r_wr_ptr + 1'b1;
            end
            if (w_acc && !w_pop) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else if (w_pop && !w_acc) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    assign w_re = (w_cnt_nxt != '0);

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_full   <= (w_cnt_nxt == L_DEPTH);
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_lost      <= '0;
            r_evnum     <= '0;
            r_prev_etag <= '0;
            r_first     <= 1'b1;
        end else if (CLR) begin
            r_lost      <= '0;
            r_evnum     <= '0;
            r_first     <= 1'b1;
        end else begin
            if (w_acc) begin
                r_evnum     <= r_evnum + 1'b1;
                r_prev_etag <= ETAG_J0;
                r_first     <= 1'b0;
            end
            if (w_drop && (r_lost != {LOST_W{1'b1}})) begin
                r_lost <= r_lost + 1'b1;
            end
        end
    end

    // r_run keeps busy asserted through the first edge after reset release.
    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_run    <= 1'b0;
            r_busy_n <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_busy_n <= ~(BUSY_LOCAL | (w_cnt_nxt >= L_AFULL) | CLR | ~r_run);
        end
    end

    tag_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (SYSCLK),
        .i_rst_n (RSTB),
        .i_we    (w_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_word),
        .i_re    (w_re),
        .i_raddr (w_rd_nxt),
        .o_q     (DOUT)
    );

    assign EMPTY   = r_empty;
    assign FULL    = r_full;
    assign COUNT   = r_cnt;
    assign LOST    = r_lost;
    assign BUSY_J0 = r_busy_n;

endmodule

// File: doc/j0_tag_fifo.md
Name: j0_tag_fifo

Overview:
- Slave-side receiver for the J0 trigger/tag bus that the GPIO-RM master drives (CLK_J0, TRIG_J0, STAG_J0, ETAG_J0, BUSY_J0).
- On each J0 trigger it captures the spill tag and event tag and stamps them with a local event number and a tag-consistency flag.
- Captured words are buffered in a FIFO for readout by the module's VME read cycle.
- It drives the active-low BUSY_J0 line back to the master when the buffer fills.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, 4..64.
- AW, 4, address width = log2(DEPTH).
- AFULL, 12, fill level at or above which busy asserts; must satisfy 1 ≤ AFULL ≤ DEPTH.

Ports:
- SYSCLK  in  1  32 MHz clock, identical to CLK_J0.
- RSTB  in  1  asynchronous active-low reset.
- TRIG_J0  in  1  J0 trigger, asynchronous level.
- STAG_J0  in  2  spill tag; stable for the whole trigger pulse.
- ETAG_J0  in  3  event tag; stable for the whole trigger pulse.
- BUSY_LOCAL  in  1  local busy request (active high), synchronous.
- CLR  in  1  synchronous clear, one-cycle pulse.
- RD_POP  in  1  one-cycle pop pulse from the VME read decoder.
- DOUT  out  32  FIFO head word (show-ahead).
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- COUNT  out  AW+1  current fill level.
- LOST  out  16  count of dropped triggers; saturates at 16'hFFFF.
- BUSY_J0  out  1  active-low busy to J0; 0 = busy.

Behaviour:
- Reset (RSTB=0, asynchronous):
  - pointers, COUNT, LOST, local event counter cleared;
  - EMPTY=1, FULL=0, DOUT=0;
  - BUSY_J0=0 (busy held during reset); sync and edge registers = 0;
  - first-event flag set.
- Trigger path:
  - TRIG_J0 passes through a 2-flop synchroniser, then a 1-flop edge register.
  - A rising edge gives a one-cycle push request 3 SYSCLK edges after the first edge that samples TRIG_J0=1.
  - STAG_J0/ETAG_J0 are sampled in the push-request cycle.
- Word format:
  - [31] = tag mismatch; [30:16] = local event number (15 bits); [15:5] = 0; [4:3] = STAG; [2:0] = ETAG.
- Local event number:
  - equals the number of triggers accepted since reset/CLR, starting at 0;
  - increments on every accepted push; wraps 7FFF→0.
- Mismatch flag:
  - set when ETAG ≠ (previous accepted ETAG + 1) mod 8.
  - Forced 0 for the first accepted event after reset/CLR, which then clears the first-event flag.
  - Dropped triggers do not update the previous-ETAG register.
- Push acceptance:
  - accepted if COUNT < DEPTH, or if RD_POP is in the same cycle.
  - Otherwise the push is dropped and LOST increments (saturating).
- Pop:
  - RD_POP with EMPTY=1 is ignored; no side effects.
  - Otherwise the read pointer advances and DOUT shows the next head one cycle later.
- Simultaneous push and pop: both execute and COUNT is unchanged.
- DOUT latency:
  - a push into an empty FIFO makes EMPTY=0 and DOUT valid on the following cycle;
  - DOUT holds its last value while EMPTY=1.
- Flags:
  - EMPTY, FULL, COUNT are registered and consistent with each other every cycle;
  - pointers wrap modulo DEPTH.
- BUSY_J0 (registered):
  - next value = ~(BUSY_LOCAL | (COUNT_next ≥ AFULL) | CLR);
  - deasserts one cycle after the condition clears.
- CLR:
  - empties the FIFO, zeroes the local event number and LOST, sets the first-event flag.
  - A push or pop in the same cycle is discarded.
  - The sync/edge pipeline is not cleared: a trigger already in flight pushes after CLR.
- Trigger held high: only one push per rising edge.
  - Pulses shorter than 1 SYSCLK period are not guaranteed to be seen.

Decomposition:
- Shared package holds:
  - J0_ETAG_W=3, J0_STAG_W=2, EVNUM_W=15;
  - word-field bit positions (MISMATCH_BIT=31, EVNUM_LSB=16, STAG_LSB=3, ETAG_LSB=0);
  - LOST_W=16.
- One sub-module, tag_fifo_mem: DEPTH×32 dual-port register file with a synchronous write port and a registered read at the read pointer.
- Pointers, flags and counters live in j0_tag_fifo.

Test Plan:
- Reset, then trigger with STAG=2, ETAG=5 → after 3 cycles COUNT=1; next cycle DOUT=32'h0000_0015, EMPTY=0; RD_POP → EMPTY=1.
- 4 triggers with ETAG 0,1,3,4 → popped words carry event numbers 0..3 and [31]=0,0,1,0.
- 17 triggers with no pops, DEPTH=16 → FULL=1, LOST=1; BUSY_J0=0 from the 12th accepted push; after 5 pops BUSY_J0 returns to 1.
- FIFO full plus trigger edge coincident with RD_POP → push accepted, COUNT stays 16, LOST stays 0.
- CLR with COUNT=5, LOST=3 → next cycle COUNT=0, EMPTY=1, LOST=0; next trigger has event number 0 and [31]=0.
- RSTB asserted mid-burst with COUNT=7 → outputs reset immediately and BUSY_J0=0; after release BUSY_J0=1 on the second SYSCLK edge.
